// File: rtl/alarm_pkg.sv
// Shared encodings and BCD limits for the alarm-clock keypad entry path.
package alarm_pkg;

    typedef enum logic [1:0] {
        MODE_DISP = 2'd0,
        MODE_SETT = 2'd1,
        MODE_SETA = 2'd2,
        MODE_DISA = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H1,
        ST_H2,
        ST_M1,
        ST_M2
    } entry_state_t;

    localparam logic [3:0] HR_TENS_MAX        = 4'd2;
    localparam logic [3:0] HR_UNITS_MAX_AT_20 = 4'd3;
    localparam logic [3:0] MIN_TENS_MAX       = 4'd5;
    localparam logic [3:0] DIGIT_MAX          = 4'd9;

endpackage

// File: rtl/alarm_entry_ctrl_if.sv
// Keypad-side and commit-side signal bundle of alarm_entry_ctrl.
interface alarm_entry_ctrl_if #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2
);
    logic [1:0]            mode;
    logic [IDX_W-1:0]      alarm_sel;
    logic                  key_valid;
    logic [3:0]            key_num;
    logic                  enable_display;
    logic [NUM_ALARMS-1:0] alarm_en;
    logic                  set_time;
    logic                  set_alarm;
    logic [IDX_W-1:0]      alarm_idx;
    logic [7:0]            hr_out;
    logic [7:0]            min_out;
    logic                  entry_err;

    modport master (
        output mode, alarm_sel, key_valid, key_num,
        input  enable_display, alarm_en, set_time, set_alarm, alarm_idx,
               hr_out, min_out, entry_err
    );

    modport slave (
        input  mode, alarm_sel, key_valid, key_num,
        output enable_display, alarm_en, set_time, set_alarm, alarm_idx,
               hr_out, min_out, entry_err
    );
endinterface

// File: rtl/alarm_entry_ctrl_bcd_digit_check.sv
// Range check of one keyed BCD digit against 24-hour HH:MM limits.
module bcd_digit_check
    import alarm_pkg::*;
(
    input  entry_state_t pos,
    input  logic [3:0]   digit,
    input  logic [3:0]   hr_tens,
    output logic         valid
);

    always_comb begin
        valid = 1'b0;
        case (pos)
            ST_H1:   valid = (digit <= HR_TENS_MAX);
            // hours 20..23 only: units digit limited once tens is 2
            ST_H2:   valid = (hr_tens == HR_TENS_MAX) ? (digit <= HR_UNITS_MAX_AT_20)
                                                      : (digit <= DIGIT_MAX);
            ST_M1:   valid = (digit <= MIN_TENS_MAX);
            ST_M2:   valid = (digit <= DIGIT_MAX);
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/alarm_entry_ctrl.sv
// Four-digit HH:MM keypad entry sequencer committing to the timekeeper or an alarm slot.
// Optional build macro ENTRY_TIMEOUT_EN aborts an entry after TIMEOUT_CYC idle cycles.
module alarm_entry_ctrl
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS  = 4,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic               clk,
    input logic               reset,
    alarm_entry_ctrl_if.slave bus
);

    if (NUM_ALARMS > (1 << IDX_W) || NUM_ALARMS < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("alarm_entry_ctrl: inconsistent parameters");
    end

    entry_state_t          state, state_d;
    mode_t                 kind, kind_d, mode_cur;
    logic [IDX_W-1:0]      slot, slot_d;
    logic [3:0]            h1, h1_d, h2, h2_d, m1, m1_d;
    logic                  disp, disp_d;
    logic [NUM_ALARMS-1:0] en, en_d;
    logic                  st, st_d, sa, sa_d, err, err_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic [7:0]            hr, hr_d, mn, mn_d;
    logic [NUM_ALARMS-1:0] sel_mask, slot_mask;
    logic                  sel_ok, dig_ok, timeout;

    assign mode_cur = mode_t'(bus.mode);

    // One-hot decode; an out-of-range alarm_sel decodes to all zeros
    always_comb begin
        sel_mask  = '0;
        slot_mask = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            sel_mask[i]  = (bus.alarm_sel == IDX_W'(i));
            slot_mask[i] = (slot == IDX_W'(i));
        end
    end
    assign sel_ok = |sel_mask;

    bcd_digit_check u_check (
        .pos     (state),
        .digit   (bus.key_num),
        .hr_tens (h1),
        .valid   (dig_ok)
    );

`ifdef ENTRY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TO_W-1:0] to_cnt;

    // Held at zero in IDLE, so entry start clears it implicitly
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   to_cnt <= '0;
        else if (state == ST_IDLE || bus.key_valid)  to_cnt <= '0;
        else                                         to_cnt <= to_cnt + 1'b1;
    end
    assign timeout = (state != ST_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state;
        kind_d  = kind;
        slot_d  = slot;
        h1_d    = h1;
        h2_d    = h2;
        m1_d    = m1;
        en_d    = en;
        st_d    = 1'b0;
        sa_d    = 1'b0;
        err_d   = 1'b0;
        idx_d   = idx;
        hr_d    = hr;
        mn_d    = mn;
        case (state)
            ST_IDLE: begin
                case (mode_cur)
                    MODE_SETT: begin
                        state_d = ST_H1;
                        kind_d  = MODE_SETT;
                        slot_d  = bus.alarm_sel;
                    end
                    MODE_SETA: begin
                        if (sel_ok) begin
                            state_d = ST_H1;
                            kind_d  = MODE_SETA;
                            slot_d  = bus.alarm_sel;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    MODE_DISA: en_d = en & ~sel_mask;
                    default: ;
                endcase
            end
            default: begin
                // Mode change beats a same-cycle key, a key beats timeout
                if (mode_cur != kind) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (bus.key_valid) begin
                    if (!dig_ok) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        case (state)
                            ST_H1: begin h1_d = bus.key_num; state_d = ST_H2; end
                            ST_H2: begin h2_d = bus.key_num; state_d = ST_M1; end
                            ST_M1: begin m1_d = bus.key_num; state_d = ST_M2; end
                            default: begin
                                state_d = ST_IDLE;
                                hr_d    = {h1, h2};
                                mn_d    = {m1, bus.key_num};
                                if (kind == MODE_SETA) begin
                                    sa_d  = 1'b1;
                                    idx_d = slot;
                                    en_d  = en | slot_mask;
                                end else begin
                                    st_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
        endcase
        disp_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            kind  <= MODE_DISP;
            slot  <= '0;
            h1    <= '0;
            h2    <= '0;
            m1    <= '0;
            disp  <= 1'b1;
            en    <= '1;
            st    <= 1'b0;
            sa    <= 1'b0;
            err   <= 1'b0;
            idx   <= '0;
            hr    <= 8'h00;
            mn    <= 8'h00;
        end else begin
            state <= state_d;
            kind  <= kind_d;
            slot  <= slot_d;
            h1    <= h1_d;
            h2    <= h2_d;
            m1    <= m1_d;
            disp  <= disp_d;
            en    <= en_d;
            st    <= st_d;
            sa    <= sa_d;
            err   <= err_d;
            idx   <= idx_d;
            hr    <= hr_d;
            mn    <= mn_d;
        end
    end

    assign bus.enable_display = disp;
    assign bus.alarm_en       = en;
    assign bus.set_time       = st;
    assign bus.set_alarm      = sa;
    assign bus.alarm_idx      = idx;
    assign bus.hr_out         = hr;
    assign bus.min_out        = mn;
    assign bus.entry_err      = err;

endmodule

// File: tb/tb_alarm_entry_ctrl.sv
// Directed plus randomized keypad stimulus against a digit-list reference model.
module tb_alarm_entry_ctrl;
    localparam int NA = 4;
    localparam int IW = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;

    alarm_entry_ctrl_if #(.NUM_ALARMS(NA), .IDX_W(IW)) bus();

    alarm_entry_ctrl #(.NUM_ALARMS(NA), .IDX_W(IW), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: an entry is a list of accepted digits plus its kind and slot
    bit              active;
    int              kind, slot, ndig, idle;
    int              dig [4];
    logic [NA-1:0]   m_en;
    logic            m_disp, m_st, m_sa, m_err;
    logic [IW-1:0]   m_idx;
    logic [7:0]      m_hr, m_min;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit digit_ok(input int pos, input int d);
        case (pos)
            0:       return d <= 2;
            1:       return d <= 9 && (dig[0] * 10 + d) <= 23;
            2:       return d <= 5;
            default: return d <= 9;
        endcase
    endfunction

    function automatic int good_digit();
        if (!active) return $urandom_range(0, 9);
        case (ndig)
            0:       return $urandom_range(0, 2);
            1:       return (dig[0] == 2) ? $urandom_range(0, 3) : $urandom_range(0, 9);
            2:       return $urandom_range(0, 5);
            default: return $urandom_range(0, 9);
        endcase
    endfunction

    task automatic model_reset();
        active = 0; kind = 0; slot = 0; ndig = 0; idle = 0;
        m_en = '1; m_disp = 1'b1; m_st = 1'b0; m_sa = 1'b0; m_err = 1'b0;
        m_idx = '0; m_hr = 8'h00; m_min = 8'h00;
    endtask

    task automatic model_step(input int mode, input int sel, input bit kv, input int kn);
        m_st = 1'b0; m_sa = 1'b0; m_err = 1'b0;
        if (!active) begin
            if (mode == 1 || (mode == 2 && sel < NA)) begin
                active = 1; kind = mode; slot = sel; ndig = 0; idle = 0;
            end else if (mode == 2) begin
                m_err = 1'b1;
            end else if (mode == 3 && sel < NA) begin
                m_en[sel] = 1'b0;
            end
        end else if (mode != kind) begin
            active = 0; m_err = 1'b1;
        end else if (kv) begin
            if (!digit_ok(ndig, kn)) begin
                active = 0; m_err = 1'b1;
            end else begin
                dig[ndig] = kn; ndig++; idle = 0;
                if (ndig == 4) begin
                    active = 0;
                    m_hr  = 8'(dig[0] * 16 + dig[1]);
                    m_min = 8'(dig[2] * 16 + dig[3]);
                    if (kind == 2) begin
                        m_sa = 1'b1; m_idx = IW'(slot); m_en[slot] = 1'b1;
                    end else begin
                        m_st = 1'b1;
                    end
                end
            end
        end else begin
`ifdef ENTRY_TIMEOUT_EN
            if (idle == TO - 1) begin
                active = 0; m_err = 1'b1;
            end else begin
                idle++;
            end
`endif
        end
        m_disp = !active;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_disp"}, 32'(bus.enable_display), 32'(m_disp));
        chk({tag, "_en"},   32'(bus.alarm_en),       32'(m_en));
        chk({tag, "_st"},   32'(bus.set_time),       32'(m_st));
        chk({tag, "_sa"},   32'(bus.set_alarm),      32'(m_sa));
        chk({tag, "_idx"},  32'(bus.alarm_idx),      32'(m_idx));
        chk({tag, "_hr"},   32'(bus.hr_out),         32'(m_hr));
        chk({tag, "_min"},  32'(bus.min_out),        32'(m_min));
        chk({tag, "_err"},  32'(bus.entry_err),      32'(m_err));
    endtask

    task automatic cyc(input int mode, input int sel, input bit kv, input int kn);
        bus.mode      = 2'(mode);
        bus.alarm_sel = IW'(sel);
        bus.key_valid = kv;
        bus.key_num   = 4'(kn);
        model_step(mode, sel, kv, kn);
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    initial begin
        int rmode, rsel, kn;
        bit kv;
        reset = 1'b1;
        bus.mode = 2'd0; bus.alarm_sel = '0; bus.key_valid = 1'b0; bus.key_num = 4'd0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // SETA slot 1, 07:30
        cyc(2, 1, 0, 0);
        chk("tp1_disp_low", 32'(bus.enable_display), 32'd0);
        cyc(2, 1, 1, 0); cyc(2, 1, 1, 7); cyc(2, 1, 1, 3); cyc(2, 1, 1, 0);
        chk("tp1_sa",  32'(bus.set_alarm), 32'd1);
        chk("tp1_idx", 32'(bus.alarm_idx), 32'd1);
        chk("tp1_hr",  32'(bus.hr_out),    32'h07);
        chk("tp1_min", 32'(bus.min_out),   32'h30);
        cyc(0, 0, 0, 0);

        // SETT 2,4 rejected; then 23:59 accepted
        cyc(1, 0, 0, 0); cyc(1, 0, 1, 2); cyc(1, 0, 1, 4);
        chk("tp2_err", 32'(bus.entry_err), 32'd1);
        cyc(1, 0, 0, 0); cyc(1, 0, 1, 2); cyc(1, 0, 1, 3); cyc(1, 0, 1, 5); cyc(1, 0, 1, 9);
        chk("tp2_st",  32'(bus.set_time), 32'd1);
        chk("tp2_hr",  32'(bus.hr_out),   32'h23);
        chk("tp2_min", 32'(bus.min_out),  32'h59);
        cyc(0, 0, 0, 0);

        // Disarm slot 2, then re-arm it via SETA 06:00
        cyc(3, 2, 0, 0);
        chk("tp3_disa", 32'(bus.alarm_en), 32'b1011);
        cyc(2, 2, 0, 0); cyc(2, 2, 1, 0); cyc(2, 2, 1, 6); cyc(2, 2, 1, 0); cyc(2, 2, 1, 0);
        chk("tp3_rearm", 32'(bus.alarm_en), 32'b1111);
        cyc(0, 0, 0, 0);

        // Mode change mid-entry aborts without commit
        cyc(1, 0, 0, 0); cyc(1, 0, 1, 1); cyc(1, 0, 1, 2); cyc(0, 0, 0, 0);
        chk("tp4_err", 32'(bus.entry_err), 32'd1);
        chk("tp4_hr",  32'(bus.hr_out),    32'h06);

        // Asynchronous reset mid-entry
        cyc(1, 0, 0, 0); cyc(1, 0, 1, 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst_async_hr", 32'(bus.hr_out), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 0, 0, 0);

`ifdef ENTRY_TIMEOUT_EN
        cyc(1, 0, 0, 0); cyc(1, 0, 1, 1);
        for (int i = 0; i < TO - 1; i++) cyc(1, 0, 0, 0);
        chk("to_pre", 32'(bus.entry_err), 32'd0);
        cyc(1, 0, 0, 0);
        chk("to_err", 32'(bus.entry_err), 32'd1);
        chk("to_disp", 32'(bus.enable_display), 32'd1);
        cyc(1, 0, 0, 0); cyc(1, 0, 1, 1);
        for (int i = 0; i < TO - 1; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 2);
        chk("to_key_wins", 32'(bus.entry_err), 32'd0);
        chk("to_key_disp", 32'(bus.enable_display), 32'd0);
        cyc(0, 0, 0, 0);
`endif

        rmode = 0; rsel = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) rmode = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0)  rsel  = $urandom_range(0, NA - 1);
            kv = ($urandom_range(0, 2) == 0);
            kn = ($urandom_range(0, 3) != 0) ? good_digit() : $urandom_range(0, 15);
            cyc(rmode, rsel, kv, kn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_entry_ctrl.md
Name: alarm_entry_ctrl

Overview:
Keypad entry sequencer for the alarm clock, and the multi-alarm successor to the single-alarm control unit. It collects four BCD digits (HH:MM) per entry, validates each digit against 24-hour limits, and commits the result either to the timekeeper or to one of NUM_ALARMS alarm slots. It also keeps a per-slot alarm-enable mask and blanks the display while an entry is in progress. It sits between the keypad debouncer and the timekeeper/alarm-compare blocks.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..16)
IDX_W, 2, width of the slot index; must satisfy 2**IDX_W >= NUM_ALARMS
TIMEOUT_CYC, 1000, idle clk cycles allowed between digits before an entry aborts (used only with ENTRY_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mode  input  2  0=DISP, 1=SETT (set time), 2=SETA (set alarm), 3=DISA (disarm alarm)
alarm_sel  input  IDX_W  target slot for SETA/DISA
key_valid  input  1  one-cycle strobe; key_num is valid this cycle
key_num  input  4  BCD digit
enable_display  output  1  1 = show time; 0 while an entry is in progress
alarm_en  output  NUM_ALARMS  per-slot arm mask
set_time  output  1  one-cycle commit strobe to the timekeeper
set_alarm  output  1  one-cycle commit strobe to the alarm register file
alarm_idx  output  IDX_W  slot being written; valid with set_alarm
hr_out  output  8  committed hours, packed BCD {tens,units}
min_out  output  8  committed minutes, packed BCD
entry_err  output  1  one-cycle strobe on an invalid digit or an aborted entry

Behaviour:
- Clock and reset: reset is asynchronous and active-high; clk is the only clock. All outputs are registered.
- Reset values: enable_display=1, alarm_en=all 1s, set_time=0, set_alarm=0, alarm_idx=0, hr_out=8'h00, min_out=8'h00, entry_err=0, FSM=IDLE, digit buffers=0.
- FSM states: IDLE, H1, H2, M1, M2.
- IDLE:
  - mode is SETT or SETA: latch the entry kind and alarm_sel, go to H1, drive enable_display=0.
  - mode is DISA: clear alarm_en[alarm_sel] on every cycle DISA is held; stay in IDLE.
  - mode is DISP: no action.
- Digit capture: in H1..M2, a digit is captured only on a cycle where key_valid=1. Each captured digit is range-checked:
  - H1 (hour tens): 0..2
  - H2 (hour units): 0..9, or 0..3 when the hour tens digit is 2
  - M1 (minute tens): 0..5
  - M2 (minute units): 0..9
- Valid digit: store it and advance H1→H2→M1→M2.
- Invalid digit: entry_err=1 for one cycle; return to IDLE; enable_display=1; nothing is committed.
- Commit on a valid M2 digit. On that clk edge:
  - hr_out and min_out load the full four-digit value, including the M2 digit just captured (no stale minute unit).
  - set_time (SETT) or set_alarm (SETA) goes to 1 for exactly one cycle.
  - For SETA: alarm_idx = latched slot and alarm_en[slot] is set to 1 on the same edge.
  - enable_display returns to 1; FSM goes to IDLE.
  - Latency: one clk from the last key_valid to the strobe.
- Mode change mid-entry: if mode differs from the latched entry kind, abort on that cycle. entry_err pulses, FSM goes to IDLE, enable_display=1, no commit. A new entry can start the following cycle.
- alarm_sel changes after entry start are ignored.
- Slot range: an alarm_sel >= NUM_ALARMS is invalid.
  - At entry start: entry_err pulses and the entry is not started.
  - In DISA: no effect.
- Re-entry: holding SETT/SETA after a commit starts a new entry on the next cycle. Strobes never assert on consecutive cycles.
- Reset mid-entry: immediate return to reset values; partial digits are discarded.

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined:
  - A counter clears on every captured digit and on entry start, and counts clk cycles while in H1..M2.
  - When it reaches TIMEOUT_CYC-1 without a key: entry_err pulses, FSM goes to IDLE, enable_display=1.
  - A key_valid on the same cycle as the timeout wins: the digit is processed and the counter clears.
- Undefined: no counter is instantiated; an entry waits indefinitely.

Decomposition:
- Shared package alarm_pkg:
  - mode encodings MODE_DISP/SETT/SETA/DISA
  - FSM state enum entry_state_t
  - BCD limit constants HR_TENS_MAX=2, HR_UNITS_MAX_AT_20=3, MIN_TENS_MAX=5, DIGIT_MAX=9
- One sub-module, bcd_digit_check (combinational): takes position, digit, and the stored hour tens; returns valid.

Test Plan:
- SETA, alarm_sel=1, keys 0,7,3,0 → one set_alarm pulse, alarm_idx=1, hr_out=8'h07, min_out=8'h30, alarm_en[1]=1, enable_display low from entry start through the commit edge.
- SETT, keys 2,4 → entry_err pulse on the "4" (24 invalid), no set_time, display restored; then 2,3,5,9 → set_time, hr_out=8'h23, min_out=8'h59.
- DISA with alarm_sel=2 for 1 cycle → alarm_en=4'b1011; then SETA slot 2 with 0,6,0,0 → alarm_en=4'b1111.
- SETT, keys 1,2, then mode→DISP → entry_err pulse, no commit, hr_out unchanged; reset asserted mid-entry → all outputs at reset values asynchronously.
- ENTRY_TIMEOUT_EN, TIMEOUT_CYC=16: SETT, key 1, no key for 16 cycles → entry_err at cycle 16, FSM=IDLE; repeat with a key on the timeout cycle → digit accepted, no error.
